// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
//   Run/pause/clear sequencer for a 4-bit counter feeding the HEX0 decoder.
//   Conditions three active-low push buttons into start/stop/clear commands,
//   divides clk into count ticks, gates those ticks onto the counter enable,
//   and stops (one-shot) or wraps (cyclic) when the counter reaches `limit`.
//
// Parameters
//   DIV  clk cycles per count tick (2..2^PW)
//   PW   prescaler width, 2^PW >= DIV
//
// Ports
//   clk, aclr          clock (rising edge), async reset (active-low)
//   start_n, stop_n,   push buttons, active-low, asynchronous to clk
//   clr_n
//   one_shot           1 = stop at limit (DONE), 0 = wrap to 0 at limit
//   limit[3:0]         terminal count, sampled every cycle
//   cnt_q[3:0]         current counter value
//   cnt_en             counter enable, one clk wide per tick
//   cnt_aclr_n         counter async clear, active-low
//   state[1:0]         00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done               high while in DONE
module counter_run_ctrl #(
  parameter int DIV = 4,
  parameter int PW  = 2
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       start_n,
  input  logic       stop_n,
  input  logic       clr_n,
  input  logic       one_shot,
  input  logic [3:0] limit,
  input  logic [3:0] cnt_q,
  output logic       cnt_en,
  output logic       cnt_aclr_n,
  output logic [1:0] state,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // Button vectors are ordered {clr, stop, start}.
  logic [2:0]    btn_n;
  logic [2:0]    s1_q, s1_d;
  logic [2:0]    s2_q, s2_d;
  logic [2:0]    p_q, p_d;
  logic [2:0]    cmd;
  logic          start_cmd, stop_cmd, clr_cmd;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clr_pulse_n_q, clr_pulse_n_d;
  logic          done_q, done_d;
  logic          tick, hit;

  assign btn_n = {clr_n, stop_n, start_n};

  // Falling edge of the synchronized level: one pulse per press, none on release.
  assign cmd       = p_q & ~s2_q;
  assign start_cmd = cmd[0];
  assign stop_cmd  = cmd[1];
  assign clr_cmd   = cmd[2];

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign hit  = (cnt_q == limit);

  // A coinciding stop or clear swallows the tick's count.
  assign cnt_en = tick & ~hit & ~stop_cmd & ~clr_cmd;

  // Reset must clear the counter for as long as it is held, not just one cycle.
  assign cnt_aclr_n = aclr & clr_pulse_n_q;
  assign state      = state_q;
  assign done       = done_q;

  always_comb begin
    s1_d          = btn_n;
    s2_d          = s1_q;
    p_d           = s2_q;
    state_d       = state_q;
    presc_d       = presc_q;
    clr_pulse_n_d = 1'b1;

    if (clr_cmd) begin
      state_d       = S_IDLE;
      presc_d       = '0;
      clr_pulse_n_d = 1'b0;
    end else if (stop_cmd && state_q == S_RUN) begin
      // Prescaler holds so a resume continues the partial tick period.
      state_d = S_PAUSE;
    end else if (start_cmd && state_q == S_IDLE) begin
      state_d = S_RUN;
      presc_d = '0;
    end else if (start_cmd && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      if (tick && hit) begin
        if (one_shot) state_d       = S_DONE;
        else          clr_pulse_n_d = 1'b0;  // wrap by clearing the counter
      end
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      s1_q          <= 3'b111;
      s2_q          <= 3'b111;
      p_q           <= 3'b111;
      state_q       <= S_IDLE;
      presc_q       <= '0;
      clr_pulse_n_q <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      p_q           <= p_d;
      state_q       <= state_d;
      presc_q       <= presc_d;
      clr_pulse_n_q <= clr_pulse_n_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: a 4-bit counter plant closes the loop, a
// behavioural model predicts every output each cycle, and a few directed
// scenarios pin the model with hand-computed numbers.
module tb_counter_run_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic [2:0] btn_n = 3'b111;  // {clr, stop, start}
  logic       one_shot = 1'b1;
  logic [3:0] limit = 4'd5;
  logic [3:0] cnt_plant = 4'd0;
  logic       cnt_en, cnt_aclr_n, done;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // cycle monitors (only ever written by the stimulus process)
  int n_en = 0, n_lo = 0, n_run = 0;
  int prev_st = 0;

  always #5 clk = ~clk;

  counter_run_ctrl #(.DIV(DIV), .PW(2)) dut (
    .clk(clk), .aclr(aclr),
    .start_n(btn_n[0]), .stop_n(btn_n[1]), .clr_n(btn_n[2]),
    .one_shot(one_shot), .limit(limit), .cnt_q(cnt_plant),
    .cnt_en(cnt_en), .cnt_aclr_n(cnt_aclr_n), .state(state), .done(done)
  );

  // Counter plant: T-flip-flop counter with async clear.
  always @(posedge clk or negedge cnt_aclr_n) begin
    if (!cnt_aclr_n) cnt_plant <= 4'd0;
    else if (cnt_en) cnt_plant <= cnt_plant + 4'd1;
  end

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 running, 2 paused, 3 finished.
  int       m_ph = 0;
  int       m_pr = 0;     // position within the current tick period
  int       m_cnt = 0;    // counter value the board should show
  bit       m_clr = 1'b0; // counter is being cleared this cycle
  bit [2:0] hist [3] = '{3'b111, 3'b111, 3'b111};  // button samples, [0] newest

  function automatic bit [2:0] m_cmd();
    return hist[2] & ~hist[1];   // pressed: was released, now seen low
  endfunction

  function automatic bit m_en();
    bit [2:0] c;
    c = m_cmd();
    return (m_ph == 1) && (m_pr == DIV - 1) && (m_cnt != int'(limit)) && !c[1] && !c[2];
  endfunction

  always @(posedge clk or negedge aclr) begin : mdl
    bit [2:0] c;
    int ph, pr, cn;
    bit clrn;
    if (!aclr) begin
      m_ph <= 0; m_pr <= 0; m_cnt <= 0; m_clr <= 1'b0;
      hist <= '{3'b111, 3'b111, 3'b111};
    end else begin
      c    = m_cmd();
      cn   = m_clr ? 0 : (m_en() ? (m_cnt + 1) % 16 : m_cnt);
      ph   = m_ph;
      pr   = m_pr;
      clrn = 1'b0;
      if (c[2]) begin
        ph = 0; pr = 0; clrn = 1'b1;
      end else if (c[1] && m_ph == 1) begin
        ph = 2;
      end else if (c[0] && m_ph == 0) begin
        ph = 1; pr = 0;
      end else if (c[0] && m_ph == 2) begin
        ph = 1;
      end else if (m_ph == 1) begin
        if (m_pr == DIV - 1 && m_cnt == int'(limit)) begin
          if (one_shot) ph = 3; else clrn = 1'b1;
        end
        pr = (m_pr + 1) % DIV;
      end
      if (clrn) cn = 0;
      m_ph <= ph; m_pr <= pr; m_cnt <= cn; m_clr <= clrn;
      hist <= '{btn_n, hist[0], hist[1]};
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare against the model mid-cycle, then advance to just
  // after the next rising edge where stimulus is applied.
  task automatic step();
    @(negedge clk);
    if (chk_on) begin
      chk("state", int'(state), m_ph);
      chk("done", int'(done), int'(m_ph == 3));
      chk("cnt_en", int'(cnt_en), int'(m_en()));
      chk("cnt_aclr_n", int'(cnt_aclr_n), int'(aclr && !m_clr));
      chk("cnt_q", int'(cnt_plant), m_cnt);
    end
    if (cnt_en) n_en++;
    if (!cnt_aclr_n) n_lo++;
    if (state == 2'b01 && prev_st != 1) n_run++;
    prev_st = int'(state);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int b, input int hold);
    btn_n[b] = 1'b0;
    steps(hold);
    btn_n[b] = 1'b1;
  endtask

  task automatic wait_cnt(input string name, input int v);
    int i;
    for (i = 0; i < 200; i++) begin
      if (int'(cnt_plant) == v) break;
      step();
    end
    if (i == 200) chk({name, "_timeout"}, int'(cnt_plant), v);
  endtask

  initial begin
    int b_en, b_lo, b_run, c0, i;

    steps(3);
    chk("rst_state", int'(state), 0);
    chk("rst_aclr_n", int'(cnt_aclr_n), 0);
    chk("rst_en", int'(cnt_en), 0);
    aclr = 1'b1;
    chk_on = 1'b1;

    // 1: idle after reset, no buttons
    b_en = n_en;
    steps(100);
    chk("t1_state", int'(state), 0);
    chk("t1_en_pulses", n_en - b_en, 0);
    chk("t1_aclr_n", int'(cnt_aclr_n), 1);

    // 2: one-shot to limit 5
    b_en = n_en;
    press(0, 2);
    steps(40);
    chk("t2_en_pulses", n_en - b_en, 5);
    chk("t2_state", int'(state), 3);
    chk("t2_done", int'(done), 1);
    chk("t2_cnt", int'(cnt_plant), 5);
    steps(10);
    chk("t2_en_after_done", n_en - b_en, 5);

    // 3: cyclic to limit 9
    one_shot = 1'b0;
    limit = 4'd9;
    press(2, 2);
    steps(5);
    chk("t3_idle", int'(state), 0);
    b_en = n_en; b_lo = n_lo;
    press(0, 2);
    for (i = 0; i < 100; i++) begin
      step();
      if (n_lo != b_lo) break;
    end
    chk("t3_wrap_seen", int'(n_lo != b_lo), 1);
    chk("t3_en_before_wrap", n_en - b_en, 9);
    chk("t3_cnt_at_wrap", int'(cnt_plant), 0);
    steps(8);
    chk("t3_en_after", n_en - b_en, 11);
    chk("t3_cnt_after", int'(cnt_plant), 2);
    chk("t3_lo_cycles", n_lo - b_lo, 1);

    // 4: pause and resume
    wait_cnt("t4_wait3", 3);
    press(1, 1);
    steps(4);
    chk("t4_paused", int'(state), 2);
    b_en = n_en;
    c0 = int'(cnt_plant);
    steps(20);
    chk("t4_no_en", n_en - b_en, 0);
    chk("t4_cnt_held", int'(cnt_plant), c0);
    b_run = n_run;
    press(0, 1);
    steps(6);
    chk("t4_resumed", int'(state), 1);
    chk("t4_run_entry", n_run - b_run, 1);

    // 5: stop and clear together, then a held start
    b_lo = n_lo;
    btn_n[1] = 1'b0; btn_n[2] = 1'b0;
    steps(2);
    btn_n = 3'b111;
    steps(4);
    chk("t5_state", int'(state), 0);
    chk("t5_lo_cycles", n_lo - b_lo, 1);
    chk("t5_cnt", int'(cnt_plant), 0);
    b_run = n_run;
    btn_n[0] = 1'b0;
    steps(50);
    btn_n[0] = 1'b1;
    steps(3);
    chk("t5_run_entries", n_run - b_run, 1);
    chk("t5_state_run", int'(state), 1);

    // 6: asynchronous reset mid-count
    wait_cnt("t6_wait7", 7);
    #1 aclr = 1'b0;
    #1;
    chk("t6_aclr_n", int'(cnt_aclr_n), 0);
    chk("t6_state", int'(state), 0);
    chk("t6_cnt", int'(cnt_plant), 0);
    chk("t6_done", int'(done), 0);
    steps(2);
    aclr = 1'b1;
    steps(3);
    chk("t6_idle_after", int'(state), 0);

    // random phase: model checks every cycle
    for (i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) btn_n[b] = ~btn_n[b];
      if ($urandom_range(0, 39) == 0) limit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) one_shot = ~one_shot;
      aclr = ($urandom_range(0, 399) != 0);
      step();
    end
    aclr = 1'b1;
    btn_n = 3'b111;
    steps(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
